// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master byte-bus arbiter.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OWN0  = 3'd1,
    OWN1  = 3'd2,
    HOLD0 = 3'd3,
    HOLD1 = 3'd4
  } arbState_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int unsigned BEAT_W = 3;

  // One-hot owner encoding for a given arbiter state.
  function automatic logic [1:0] grantOf(input arbState_t s);
    case (s)
      OWN0, HOLD0: grantOf = GRANT_M0;
      OWN1, HOLD1: grantOf = GRANT_M1;
      default:     grantOf = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_arb_if.sv
// Bundle of both master ports, the shared slave bus and arbiter status.
interface bus_arb_if;

  logic        m0Read;
  logic        m0Write;
  logic [31:0] m0Addr;
  logic [7:0]  m0DataOut;
  logic        m0Ready;
  logic [7:0]  m0DataIn;

  logic        m1Read;
  logic        m1Write;
  logic [31:0] m1Addr;
  logic [7:0]  m1DataOut;
  logic        m1Ready;
  logic [7:0]  m1DataIn;

  logic        readMem;
  logic        writeMem;
  logic [31:0] addressBus;
  logic [7:0]  dataBusIn;
  logic        memDataReady;
  logic [7:0]  dataBusOut;

  logic [1:0]  grant;
  logic        busy;

  // Arbiter view: serves both masters and drives the memory slave.
  modport slave (
    input  m0Read, m0Write, m0Addr, m0DataOut,
    input  m1Read, m1Write, m1Addr, m1DataOut,
    input  memDataReady, dataBusOut,
    output m0Ready, m0DataIn, m1Ready, m1DataIn,
    output readMem, writeMem, addressBus, dataBusIn,
    output grant, busy
  );

  // Environment view: masters plus the memory slave.
  modport master (
    output m0Read, m0Write, m0Addr, m0DataOut,
    output m1Read, m1Write, m1Addr, m1DataOut,
    output memDataReady, dataBusOut,
    input  m0Ready, m0DataIn, m1Ready, m1DataIn,
    input  readMem, writeMem, addressBus, dataBusIn,
    input  grant, busy
  );

endinterface

// File: rtl/bus_arb_pick.sv
// Owner picker: chooses the IDLE winner and decides whether the holder keeps the bus.
// BUS_ARB_ROUND_ROBIN_EN selects symmetric burst limiting; otherwise M1 yields at once.
module bus_arb_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              req0,
  input  logic              req1,
  input  logic              lastOwner,
  input  logic              owner,
  input  logic [BEAT_W-1:0] beatCnt,
  output logic              idlePick,
  output logic              keepOwner
);

  logic ownerReq;
  logic otherReq;
  logic underLimit;

  always_comb begin
    ownerReq   = (owner == M1) ? req1 : req0;
    otherReq   = (owner == M1) ? req0 : req1;
    underLimit = beatCnt < BEAT_W'(BURST_MAX);

    // A tie goes to whoever did not own last; fixed priority ties lastOwner to M1.
    if (req0 && req1) idlePick = ~lastOwner;
    else              idlePick = (req1 && !req0) ? M1 : M0;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    keepOwner = ownerReq && (!otherReq || underLimit);
`else
    keepOwner = ownerReq && (!otherReq || ((owner == M0) && underLimit));
`endif
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the byte-wide memory bus with grant hold and burst limiting.
// Define BUS_ARB_ROUND_ROBIN_EN for alternating IDLE priority; default is fixed M0 priority.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned BURST_MAX   = 4
) (
  input logic    clk,
  input logic    rst,
  bus_arb_if.slave bus
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  arbState_t         state, stateNext;
  logic [BEAT_W-1:0] beatCnt, beatNext;
  logic [HOLD_W-1:0] holdCnt, holdNext;
  logic [1:0]        grantQ;
  logic              lastOwner;

  logic m0Wr, m0Rd, req0;
  logic m1Wr, m1Rd, req1;
  logic owner, idlePick, keepOwner;
  logic readyOk;

  logic        readMemC, writeMemC;
  logic [31:0] addrC;
  logic [7:0]  wdataC;
  logic        m0ReadyC, m1ReadyC;
  logic [7:0]  m0DataC, m1DataC;

  // Write wins when a master raises both strobes.
  assign m0Wr = bus.m0Write;
  assign m0Rd = bus.m0Read & ~bus.m0Write;
  assign req0 = m0Rd | m0Wr;
  assign m1Wr = bus.m1Write;
  assign m1Rd = bus.m1Read & ~bus.m1Write;
  assign req1 = m1Rd | m1Wr;

  assign owner   = ((state == OWN1) || (state == HOLD1)) ? M1 : M0;
  assign readyOk = bus.memDataReady & ~rst;

  bus_arb_pick #(.BURST_MAX(BURST_MAX)) uPick (
    .req0      (req0),
    .req1      (req1),
    .lastOwner (lastOwner),
    .owner     (owner),
    .beatCnt   (beatCnt),
    .idlePick  (idlePick),
    .keepOwner (keepOwner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beatCnt <= '0;
      holdCnt <= '0;
      grantQ  <= GRANT_NONE;
    end else begin
      state   <= stateNext;
      beatCnt <= beatNext;
      holdCnt <= holdNext;
      grantQ  <= grantOf(stateNext);
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Reset to M1 so M0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)                    lastOwner <= M1;
    else if (stateNext == OWN0) lastOwner <= M0;
    else if (stateNext == OWN1) lastOwner <= M1;
  end
`else
  assign lastOwner = M1;
`endif

  // Next-state logic and combinational forwarding toward the slave and the owner.
  always_comb begin
    stateNext = state;
    beatNext  = beatCnt;
    holdNext  = holdCnt;
    readMemC  = 1'b0;
    writeMemC = 1'b0;
    addrC     = 32'h0;
    wdataC    = 8'h00;
    m0ReadyC  = 1'b0;
    m1ReadyC  = 1'b0;
    m0DataC   = 8'h00;
    m1DataC   = 8'h00;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          stateNext = (idlePick == M1) ? OWN1 : OWN0;
          beatNext  = '0;
        end
      end

      OWN0: begin
        readMemC  = m0Rd;
        writeMemC = m0Wr;
        addrC     = bus.m0Addr;
        wdataC    = bus.m0DataOut;
        m0DataC   = bus.dataBusOut;
        if (!req0) begin
          stateNext = HOLD0;
          holdNext  = '0;
        end else if (readyOk) begin
          m0ReadyC  = 1'b1;
          beatNext  = (beatCnt == '1) ? beatCnt : beatCnt + BEAT_W'(1);
          stateNext = HOLD0;
          holdNext  = '0;
        end
      end

      OWN1: begin
        readMemC  = m1Rd;
        writeMemC = m1Wr;
        addrC     = bus.m1Addr;
        wdataC    = bus.m1DataOut;
        m1DataC   = bus.dataBusOut;
        if (!req1) begin
          stateNext = HOLD1;
          holdNext  = '0;
        end else if (readyOk) begin
          m1ReadyC  = 1'b1;
          beatNext  = (beatCnt == '1) ? beatCnt : beatCnt + BEAT_W'(1);
          stateNext = HOLD1;
          holdNext  = '0;
        end
      end

      HOLD0: begin
        if (keepOwner) begin
          stateNext = OWN0;
        end else if (req1) begin
          stateNext = OWN1;
          beatNext  = '0;
        end else if (holdCnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          stateNext = IDLE;
        end else begin
          holdNext = holdCnt + HOLD_W'(1);
        end
      end

      HOLD1: begin
        if (keepOwner) begin
          stateNext = OWN1;
        end else if (req0) begin
          stateNext = OWN0;
          beatNext  = '0;
        end else if (holdCnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          stateNext = IDLE;
        end else begin
          holdNext = holdCnt + HOLD_W'(1);
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign bus.readMem    = readMemC;
  assign bus.writeMem   = writeMemC;
  assign bus.addressBus = addrC;
  assign bus.dataBusIn  = wdataC;
  assign bus.m0Ready    = m0ReadyC;
  assign bus.m1Ready    = m1ReadyC;
  assign bus.m0DataIn   = m0DataC;
  assign bus.m1DataIn   = m1DataC;
  assign bus.grant      = grantQ;
  assign bus.busy       = (readMemC | writeMemC) & ~bus.memDataReady;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter; honours BUS_ARB_ROUND_ROBIN_EN.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic expLast = 1'b1;

  typedef struct {
    logic        mst;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } beat_t;

  beat_t sbQ[$];

  bus_arb_if bus ();

  bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setStrobe(input logic m, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [7:0] d);
    if (m) begin
      bus.m1Read = rd; bus.m1Write = wr; bus.m1Addr = a; bus.m1DataOut = d;
    end else begin
      bus.m0Read = rd; bus.m0Write = wr; bus.m0Addr = a; bus.m0DataOut = d;
    end
  endtask

  // One byte beat for master m; called at a falling edge, returns at the next falling edge after ready.
  task automatic doBeat(input logic m, input logic wr, input logic both, input logic [31:0] a,
                        input logic [7:0] wd, input logic [7:0] rd, input int lat);
    beat_t e;
    int    n;
    logic [1:0] g;
    g = m ? 2'b10 : 2'b01;
    sbQ.push_back('{mst: m, addr: a, wr: wr, wdata: wd, rdata: rd});
    setStrobe(m, !wr || both, wr, a, wd);
    #1;
    n = 0;
    while (!((bus.readMem || bus.writeMem) && bus.grant == g) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grantWait", 32'(n < 20), 32'd1);
    repeat (lat) begin
      chk("busyWait", 32'(bus.busy), 32'd1);
      chk("earlyReady", 32'(m ? bus.m1Ready : bus.m0Ready), 32'd0);
      @(negedge clk); #1;
    end
    bus.memDataReady = 1'b1;
    bus.dataBusOut   = rd;
    #1;
    e = sbQ.pop_front();
    chk("beatAddr", bus.addressBus, e.addr);
    chk("beatWrite", 32'(bus.writeMem), 32'(e.wr));
    chk("beatRead", 32'(bus.readMem), 32'(!e.wr));
    if (e.wr) chk("beatWdata", 32'(bus.dataBusIn), 32'(e.wdata));
    chk("beatGrant", 32'(bus.grant), e.mst ? 32'd2 : 32'd1);
    chk("ownerReady", 32'(e.mst ? bus.m1Ready : bus.m0Ready), 32'd1);
    if (!e.wr) chk("ownerData", 32'(e.mst ? bus.m1DataIn : bus.m0DataIn), 32'(e.rdata));
    chk("otherReady", 32'(e.mst ? bus.m0Ready : bus.m1Ready), 32'd0);
    chk("otherData", 32'(e.mst ? bus.m0DataIn : bus.m1DataIn), 32'd0);
    expLast = e.mst;
    @(negedge clk);
    bus.memDataReady = 1'b0;
    bus.dataBusOut   = 8'h00;
    setStrobe(m, 1'b0, 1'b0, a, wd);
  endtask

  initial begin
    beat_t e;
    int    n;
    logic  cur;
    int    run;
    int    lim;

    rst = 1'b1;
    setStrobe(1'b0, 1'b1, 1'b0, 32'h0000_1000, 8'h00);
    setStrobe(1'b1, 1'b1, 1'b0, 32'h0000_2000, 8'h00);
    bus.memDataReady = 1'b0;
    bus.dataBusOut   = 8'h00;

    // Reset held with both masters reading.
    repeat (3) begin
      @(negedge clk); #1;
      chk("rstGrant", 32'(bus.grant), 32'd0);
      chk("rstRead", 32'(bus.readMem), 32'd0);
      chk("rstAddr", bus.addressBus, 32'd0);
      chk("rstBusy", 32'(bus.busy), 32'd0);
      chk("rstReady", 32'(bus.m0Ready), 32'd0);
    end
    rst = 1'b0;
    bus.m1Read = 1'b0;
    #1;
    chk("relGrantN", 32'(bus.grant), 32'd0);
    @(negedge clk); #1;
    chk("relGrantN1", 32'(bus.grant), 32'd1);
    chk("relRead", 32'(bus.readMem), 32'd1);
    chk("relAddr", bus.addressBus, 32'h0000_1000);

    // Single read with three wait cycles.
    doBeat(1'b0, 1'b0, 1'b0, 32'h0000_1000, 8'h00, 8'hA5, 3);

    // Back-to-back re-request in HOLD, then abort.
    setStrobe(1'b0, 1'b1, 1'b0, 32'h0000_1004, 8'h00);
    #1;
    chk("holdNoStrobe", 32'(bus.readMem), 32'd0);
    @(negedge clk); #1;
    chk("b2bRead", 32'(bus.readMem), 32'd1);
    chk("b2bAddr", bus.addressBus, 32'h0000_1004);
    setStrobe(1'b0, 1'b0, 1'b0, 32'h0000_1004, 8'h00);
    #1;
    chk("abortReady", 32'(bus.m0Ready), 32'd0);
    @(negedge clk); #1;
    chk("abortHold", 32'(bus.grant), 32'd1);
    chk("abortStrobe", 32'(bus.readMem), 32'd0);
    @(negedge clk); #1;
    chk("abortHold2", 32'(bus.grant), 32'd1);
    @(negedge clk); #1;
    chk("abortIdle", 32'(bus.grant), 32'd0);
    expLast = 1'b0;

    // Word lock: four M0 beats while M1 requests throughout.
    @(negedge clk);
    setStrobe(1'b1, 1'b1, 1'b0, 32'h0000_0200, 8'h00);
    for (int i = 0; i < 4; i++)
      doBeat(1'b0, 1'b0, 1'b0, 32'h0000_0100 + 32'(i), 8'h00, 8'h10 + 8'(i), (i == 0) ? 0 : 1);
    #1;
    chk("lockHold", 32'(bus.grant), 32'd1);
    @(negedge clk); #1;
    chk("lockSwitch", 32'(bus.grant), 32'd2);
    chk("lockM1Addr", bus.addressBus, 32'h0000_0200);
    @(negedge clk);
    doBeat(1'b1, 1'b0, 1'b0, 32'h0000_0200, 8'h00, 8'h77, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("lockIdle", 32'(bus.grant), 32'd0);

    // Hold timeout after an M1 write with both strobes raised.
    @(negedge clk);
    doBeat(1'b1, 1'b1, 1'b1, 32'h0000_0300, 8'h5C, 8'h00, 0);
    #1;
    chk("holdT1", 32'(bus.grant), 32'd2);
    @(negedge clk); #1;
    chk("holdT2", 32'(bus.grant), 32'd2);
    @(negedge clk); #1;
    chk("holdT3", 32'(bus.grant), 32'd0);

    // Fairness with both masters requesting continuously.
    @(negedge clk);
`ifdef BUS_ARB_ROUND_ROBIN_EN
    cur = ~expLast;
`else
    cur = 1'b0;
`endif
    run = 0;
    setStrobe(1'b0, 1'b1, 1'b0, 32'h0000_0400, 8'h00);
    setStrobe(1'b1, 1'b1, 1'b0, 32'h0000_0500, 8'h00);
    for (int k = 0; k < 12; k++) begin
      sbQ.push_back('{mst: cur, addr: cur ? 32'h0000_0500 : 32'h0000_0400,
                      wr: 1'b0, wdata: 8'h00, rdata: 8'h00});
      #1;
      n = 0;
      while (!bus.readMem && n < 10) begin
        @(negedge clk); #1; n++;
      end
      chk("fairWait", 32'(n < 10), 32'd1);
      e = sbQ.pop_front();
      chk("fairGrant", 32'(bus.grant), e.mst ? 32'd2 : 32'd1);
      chk("fairAddr", bus.addressBus, e.addr);
      bus.memDataReady = 1'b1;
      #1;
      chk("fairM0Ready", 32'(bus.m0Ready), 32'(!e.mst));
      chk("fairM1Ready", 32'(bus.m1Ready), 32'(e.mst));
      @(negedge clk);
      bus.memDataReady = 1'b0;
      expLast = e.mst;
      run++;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      lim = 4;
`else
      lim = cur ? 1 : 4;
`endif
      if (run == lim) begin
        cur = ~cur;
        run = 0;
      end
    end
    setStrobe(1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    setStrobe(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    repeat (4) @(negedge clk);
    #1;
    chk("fairIdle", 32'(bus.grant), 32'd0);

    // Reset in the middle of an M1 write beat.
    @(negedge clk);
    setStrobe(1'b1, 1'b0, 1'b1, 32'h0000_0600, 8'h33);
    #1;
    n = 0;
    while (!bus.writeMem && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("midWait", 32'(n < 10), 32'd1);
    rst = 1'b1;
    bus.memDataReady = 1'b1;
    #1;
    chk("midNoReady", 32'(bus.m1Ready), 32'd0);
    @(negedge clk);
    bus.memDataReady = 1'b0;
    #1;
    chk("midWriteDrop", 32'(bus.writeMem), 32'd0);
    chk("midGrant", 32'(bus.grant), 32'd0);
    chk("midReady2", 32'(bus.m1Ready), 32'd0);
    rst = 1'b0;
    setStrobe(1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
